// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - scanned 4x4 keypad with debounce and decimal number entry
module keypad_entry #(
    parameter int SCAN_DIV        = 10000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [31:0] value,
    output logic [3:0]  count,
    output logic        overflow,
    output logic [31:0] result,
    output logic        result_valid
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W:0]   STB_DONE = (STB_W + 1)'(DEBOUNCE_FRAMES);

    localparam logic [3:0] CODE_STAR = 4'd14;
    localparam logic [3:0] CODE_HASH = 4'd15;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [DIV_W-1:0] div;
    logic [1:0]       r;
    logic             tick;
    logic [1:0]       acc_cnt;
    logic [3:0]       acc_pos;
    logic [3:0]       col_low;
    logic [2:0]       n_low;
    logic [2:0]       frame_sum;
    logic [1:0]       c_idx;
    logic [3:0]       frame_pos;
    logic [3:0]       frame_code;
    logic             frame_done;
    logic             frame_none;
    logic             frame_key;
    state_t           state, state_d;
    logic [STB_W-1:0] stable, stable_d;
    logic [STB_W:0]   stable_inc;
    logic [3:0]       cand, cand_d;
    logic             fire;
    logic             evt;
    logic [3:0]       evt_code;

    assign tick  = (div == DIV_LAST);
    assign row_n = ~(4'b0001 << r);

    // Row dwell divider and row index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            r   <= 2'd0;
        end else if (tick) begin
            div <= '0;
            r   <= r + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Combine this row's columns with what the frame has seen so far
    always_comb begin
        col_low   = ~col_n;
        n_low     = {2'b0, col_low[0]} + {2'b0, col_low[1]} + {2'b0, col_low[2]} + {2'b0, col_low[3]};
        frame_sum = {1'b0, acc_cnt} + n_low;
        c_idx     = col_low[0] ? 2'd0 : col_low[1] ? 2'd1 : col_low[2] ? 2'd2 : 2'd3;
        frame_pos = (n_low != 3'd0) ? {r, c_idx} : acc_pos;
        case (frame_pos)
            4'd0:    frame_code = 4'd1;
            4'd1:    frame_code = 4'd2;
            4'd2:    frame_code = 4'd3;
            4'd3:    frame_code = 4'd10;
            4'd4:    frame_code = 4'd4;
            4'd5:    frame_code = 4'd5;
            4'd6:    frame_code = 4'd6;
            4'd7:    frame_code = 4'd11;
            4'd8:    frame_code = 4'd7;
            4'd9:    frame_code = 4'd8;
            4'd10:   frame_code = 4'd9;
            4'd11:   frame_code = 4'd12;
            4'd12:   frame_code = CODE_STAR;
            4'd13:   frame_code = 4'd0;
            4'd14:   frame_code = CODE_HASH;
            default: frame_code = 4'd13;
        endcase
        frame_done = tick && (r == 2'd3);
        frame_none = frame_done && (frame_sum == 3'd0);
        frame_key  = frame_done && (frame_sum == 3'd1);
    end

    // Per-frame low-bit accumulator; saturates at 2 since only "many" matters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= 2'd0;
            acc_pos <= 4'd0;
        end else if (tick) begin
            if (r == 2'd3) begin
                acc_cnt <= 2'd0;
                acc_pos <= 4'd0;
            end else begin
                acc_cnt <= (frame_sum >= 3'd2) ? 2'd2 : frame_sum[1:0];
                acc_pos <= frame_pos;
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RELEASED;
            stable <= '0;
            cand   <= 4'd0;
        end else begin
            state  <= state_d;
            stable <= stable_d;
            cand   <= cand_d;
        end
    end

    // Debounce next-state; acts only on frame boundaries
    always_comb begin
        state_d    = state;
        stable_d   = stable;
        cand_d     = cand;
        fire       = 1'b0;
        stable_inc = {1'b0, stable} + 1'b1;
        if (frame_done) begin
            case (state)
                RELEASED: begin
                    if (frame_key) begin
                        state_d  = PRESS_WAIT;
                        cand_d   = frame_code;
                        stable_d = STB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (frame_key) begin
                        if (frame_code != cand) begin
                            cand_d   = frame_code;
                            stable_d = STB_W'(1);
                        end else if (stable_inc >= STB_DONE) begin
                            state_d  = HELD;
                            stable_d = '0;
                            fire     = 1'b1;
                        end else begin
                            stable_d = stable_inc[STB_W-1:0];
                        end
                    end else begin
                        state_d  = RELEASED;
                        stable_d = '0;
                    end
                end
                HELD: begin
                    if (frame_none) begin
                        state_d  = RELEASE_WAIT;
                        stable_d = STB_W'(1);
                    end
                end
                default: begin
                    if (!frame_none) begin
                        state_d  = HELD;
                        stable_d = '0;
                    end else if (stable_inc >= STB_DONE) begin
                        state_d  = RELEASED;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_inc[STB_W-1:0];
                    end
                end
            endcase
        end
    end

    // Register the accepted key so the entry logic sees it one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt      <= 1'b0;
            evt_code <= 4'd0;
        end else begin
            evt      <= fire;
            evt_code <= cand;
        end
    end

    // Decimal entry, clear and enter handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value        <= 32'd0;
            count        <= 4'd0;
            overflow     <= 1'b0;
            result       <= 32'd0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (evt) begin
                if (evt_code <= 4'd9) begin
                    if (count < 4'd9) begin
                        value <= (value << 3) + (value << 1) + {28'd0, evt_code};
                        count <= count + 4'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (evt_code == CODE_STAR) begin
                    value    <= 32'd0;
                    count    <= 4'd0;
                    overflow <= 1'b0;
                end else if (evt_code == CODE_HASH && count != 4'd0) begin
                    result       <= value;
                    result_valid <= 1'b1;
                    value        <= 32'd0;
                    count        <= 4'd0;
                    overflow     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry
module tb_keypad_entry;
    localparam int FRAME = 16;
    localparam int K_A = 10, K_B = 11, K_STAR = 14, K_HASH = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [31:0] value;
    logic [3:0]  count;
    logic        overflow;
    logic [31:0] result;
    logic        result_valid;

    logic [15:0] pressed;
    logic [31:0] res_q[$];
    logic        prev_rv;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        int          key;
        logic [31:0] exp_value;
        logic [3:0]  exp_count;
        logic        exp_ovf;
        logic        fire;
        logic [31:0] exp_res;
    } vec_t;
    vec_t tbl[$];

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
        .value(value), .count(count), .overflow(overflow),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!row_n[rr] && pressed[rr*4+cc]) col_n[cc] = 1'b0;
    end

    function automatic int pos_of(input int k);
        case (k)
            1: return 0;   2: return 1;   3: return 2;   10: return 3;
            4: return 4;   5: return 5;   6: return 6;   11: return 7;
            7: return 8;   8: return 9;   9: return 10;  12: return 11;
            14: return 12; 0: return 13;  15: return 14; default: return 15;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            check("rv_not_consecutive", {31'd0, prev_rv}, 32'd0);
            if (res_q.size() == 0) check("unexpected_result_pulse", 32'd1, 32'd0);
            else check("result_on_pulse", result, res_q.pop_front());
        end
        prev_rv = result_valid;
    end

    task automatic align();
        int n;
        n = 0;
        @(negedge clk);
        while (row_n != 4'b0111 && n < 100) begin @(negedge clk); n++; end
        while (row_n != 4'b1110 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("align_timeout", 32'd1, 32'd0);
    endtask

    task automatic hold(input int k1, input int k2, input int frames);
        align();
        pressed = 16'd0;
        pressed[pos_of(k1)] = 1'b1;
        if (k2 >= 0) pressed[pos_of(k2)] = 1'b1;
        repeat (frames * FRAME) @(negedge clk);
        pressed = 16'd0;
    endtask

    task automatic idle(input int frames);
        repeat (frames * FRAME) @(negedge clk);
    endtask

    task automatic add(input int k, input logic [31:0] v, input logic [3:0] c,
                       input logic o, input logic f, input logic [31:0] r);
        vec_t e;
        e.key = k; e.exp_value = v; e.exp_count = c; e.exp_ovf = o; e.fire = f; e.exp_res = r;
        tbl.push_back(e);
    endtask

    initial begin
        logic [31:0] nines;
        #1_000_000;
        $display("FAIL watchdog_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] nines;
        rst_n = 1'b0;
        pressed = 16'd0;
        prev_rv = 1'b0;

        add(1, 1, 1, 0, 0, 0);
        add(2, 12, 2, 0, 0, 0);
        add(3, 123, 3, 0, 0, 0);
        add(K_HASH, 0, 0, 0, 1, 123);
        add(K_HASH, 0, 0, 0, 0, 0);
        nines = 0;
        for (int i = 1; i <= 9; i++) begin
            nines = nines * 10 + 9;
            add(9, nines, 4'(i), 0, 0, 0);
        end
        add(9, 999999999, 9, 1, 0, 0);
        add(K_STAR, 0, 0, 0, 0, 0);
        add(K_A, 0, 0, 0, 0, 0);
        add(4, 4, 1, 0, 0, 0);
        add(K_B, 4, 1, 0, 0, 0);
        add(2, 42, 2, 0, 0, 0);
        add(K_HASH, 0, 0, 0, 1, 42);

        repeat (3) @(negedge clk);
        check("rst_row_n", {28'd0, row_n}, 32'hE);
        check("rst_value", value, 0);
        check("rst_count", {28'd0, count}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_result", result, 0);
        check("rst_rv", {31'd0, result_valid}, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].fire) res_q.push_back(tbl[i].exp_res);
            hold(tbl[i].key, -1, 3);
            idle(3);
            check($sformatf("tbl%0d_value", i), value, tbl[i].exp_value);
            check($sformatf("tbl%0d_count", i), {28'd0, count}, {28'd0, tbl[i].exp_count});
            check($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
        end
        check("result_after_table", result, 42);

        for (int i = 0; i < 3; i++) begin
            hold(5, -1, 1);
            idle(1);
        end
        check("bounce_no_event", value, 0);
        hold(5, -1, 2);
        idle(3);
        check("bounce_then_accept", value, 5);
        check("bounce_count", {28'd0, count}, 1);

        hold(K_STAR, -1, 3); idle(3);
        hold(7, -1, 20); idle(3);
        check("long_hold_value", value, 7);
        check("long_hold_count", {28'd0, count}, 1);
        hold(1, 9, 4); idle(3);
        check("multi_value", value, 7);
        check("multi_count", {28'd0, count}, 1);
        hold(K_STAR, -1, 3); idle(3);

        align();
        pressed = 16'd0;
        pressed[pos_of(6)] = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("latency_before", value, 0);
        @(posedge clk);
        @(negedge clk);
        check("latency_after", value, 6);
        pressed = 16'd0;
        idle(4);

        res_q.push_back(6);
        hold(K_HASH, -1, 3); idle(3);
        check("enter_clears_value", value, 0);
        hold(K_HASH, -1, 3); idle(3);
        check("empty_enter_result", result, 6);
        check("queue_drained", res_q.size(), 0);

        hold(3, -1, 3); idle(3);
        check("pre_reset_value", value, 3);
        align();
        pressed = 16'd0;
        pressed[pos_of(8)] = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_row_n", {28'd0, row_n}, 32'hE);
        check("midrst_value", value, 0);
        check("midrst_count", {28'd0, count}, 0);
        check("midrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("post_rst_before", value, 0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_value", value, 8);
        check("post_rst_count", {28'd0, count}, 1);
        pressed = 16'd0;
        idle(4);
        check("final_queue_empty", res_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 10000: clk cycles per row dwell.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 3: consecutive identical scan frames needed to accept a press or release.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port col_n  input  4  keypad columns, active-low, externally pulled up.
REQ-006 SHALL have port row_n  output  4  keypad rows, exactly one bit low (driven row).
REQ-007 SHALL have port value  output  32  binary value of digits entered so far.
REQ-008 SHALL have port count  output  4  number of digits entered, 0..9.
REQ-009 SHALL have port overflow  output  1  sticky: a digit was rejected because count was 9.
REQ-010 SHALL have port result  output  32  value latched at last accepted enter.
REQ-011 SHALL have port result_valid  output  1  one-cycle pulse when result updates.

Function
REQ-012 Scan: divider counts 0..SCAN_DIV-1; the terminal count is the "tick"; row index r (0..3) advances by 1 on each tick, wrapping 3->0; row_n = ~(1<<r).
REQ-013 col_n SHALL be sampled on the tick cycle, before r advances, and attributed to the current row r.
REQ-014 Key map by (row,col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D; col index c = bit position of the low col_n bit.
REQ-015 Frame = 4 ticks (r=0..3); frame result = NONE (no low bits), KEY(code) (exactly one low bit across the frame), or MULTI (two or more).
REQ-016 Debounce FSM states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-017 RELEASED: KEY(k) -> PRESS_WAIT, candidate=k, stable=1; NONE/MULTI stay.
REQ-018 PRESS_WAIT: KEY(same k) increments stable; stable reaching DEBOUNCE_FRAMES -> HELD and fires one key event; KEY(other) restarts with new candidate, stable=1; NONE or MULTI -> RELEASED.
REQ-019 HELD: NONE -> RELEASE_WAIT, stable=1; KEY/MULTI stay (no repeat, no new event).
REQ-020 RELEASE_WAIT: NONE increments stable; reaching DEBOUNCE_FRAMES -> RELEASED; any KEY/MULTI -> HELD.
REQ-021 Key event latency: value/count/overflow/result SHALL update on the clk edge one cycle after the tick completing the accepting frame.
REQ-022 Digit d with count<9: value <= value*10 + d (shift-add, 32-bit; max 999999999, no wrap), count <= count+1.
REQ-023 Digit with count==9: value and count unchanged, overflow <= 1.
REQ-024 '*': value <= 0, count <= 0, overflow <= 0.
REQ-025 '#' with count>0: result <= value, result_valid = 1 for exactly one cycle, value <= 0, count <= 0, overflow <= 0.
REQ-026 '#' with count==0: ignored; no pulse, result unchanged.
REQ-027 Keys A, B, C, D: accepted by FSM (consume press) but no effect on outputs.
REQ-028 At most one key event per frame; result_valid never asserted on consecutive cycles.

Reset
REQ-029 rst_n low SHALL immediately force: divider=0, r=0, row_n=4'b1110, FSM=RELEASED, stable=0, value=0, count=0, overflow=0, result=0, result_valid=0.
REQ-030 Reset mid-press: after rst_n rises, a key still held SHALL be debounced from scratch (DEBOUNCE_FRAMES full frames) and produce one event.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2)
REQ-031 Press 1,2,3 then # (each held 3 frames, released 3 frames) -> value steps 1,12,123; result=123, one result_valid pulse, value=0, count=0.
REQ-032 Enter 4294967295-style sequence 9,9,9,9,9,9,9,9,9,9 -> value=999999999, count=9, overflow=1 after 10th; * -> all zero.
REQ-033 Bounce: key 5 low for 1 frame, released, repeated -> no event; held 2 frames -> exactly one event, value=5.
REQ-034 Hold key 7 for 20 frames -> single event, value=7; two keys (1 and 9) held together -> no event.
REQ-035 # with count=0 -> no pulse, result unchanged; rst_n asserted mid-debounce of 8 -> outputs zero, row_n=4'b1110 immediately; key still held -> value=8 after 2 new frames.
